// File: rtl/vend_ctrl.sv
// vend_ctrl: N-item vending controller with one-hot coin/buy inputs,
// two-digit decimal credit display, per-item affordable LEDs and a
// change-return sequencer that pays credit back as coins.
module vend_ctrl #(
    parameter int                   N_ITEMS    = 3,
    parameter logic [7*N_ITEMS-1:0] PRICES     = {7'd20, 7'd15, 7'd10},
    parameter int                   CREDIT_MAX = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         insert,
    input  logic [N_ITEMS-1:0] buy,
    input  logic               ret,
    output logic [N_ITEMS-1:0] LEDout,
    output logic [N_ITEMS-1:0] vend,
    output logic               deny,
    output logic               coin_reject,
    output logic [3:0]         coin_out,
    output logic               done,
    output logic [6:0]         Ten,
    output logic [6:0]         One
);

    typedef enum logic {S_IDLE, S_CHANGE} state_t;

    localparam logic [7:0] LP_MAX = 8'(CREDIT_MAX);

    state_t             r_state, w_nxt_state;
    logic [6:0]         r_credit, w_nxt_credit;
    logic [3:0]         r_ins_prev;
    logic [N_ITEMS-1:0] r_buy_prev;
    logic               r_ret_prev;

    logic [N_ITEMS-1:0] r_vend, w_nxt_vend;
    logic               r_deny, w_nxt_deny;
    logic               r_coin_reject, w_nxt_coin_reject;
    logic [3:0]         r_coin_out, w_nxt_coin_out;
    logic               r_done, w_nxt_done;

    logic [3:0]         w_ins_rise;
    logic [N_ITEMS-1:0] w_buy_rise;
    logic               w_ret_rise;
    logic [6:0]         w_sel_price;
    logic [6:0]         w_after_buy;
    logic [6:0]         w_coin_val;
    logic [7:0]         w_sum;
    logic [N_ITEMS-1:0] w_led;
    logic [6:0]         w_tens, w_ones;

    assign w_ins_rise = insert & ~r_ins_prev;
    assign w_buy_rise = buy & ~r_buy_prev;
    assign w_ret_rise = ret & ~r_ret_prev;

    // Previous-value copies track inputs every cycle, including during
    // reset, so a level held through reset never looks like a new edge.
    always_ff @(posedge clk) begin
        r_ins_prev <= insert;
        r_buy_prev <= buy;
        r_ret_prev <= ret;
    end

    // Price of the requested item (only meaningful when one buy bit rose).
    always_comb begin
        w_sel_price = '0;
        for (int i = 0; i < N_ITEMS; i++)
            if (w_buy_rise[i]) w_sel_price = PRICES[7*i +: 7];
    end

    // Next-state, next-credit and pulse decode.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_credit      = r_credit;
        w_nxt_vend        = '0;
        w_nxt_deny        = 1'b0;
        w_nxt_coin_reject = 1'b0;
        w_nxt_coin_out    = '0;
        w_nxt_done        = 1'b0;
        w_after_buy       = r_credit;
        w_coin_val        = '0;
        w_sum             = '0;
        case (r_state)
            S_IDLE: begin
                // Buy is judged on current credit; the coin is then checked
                // against what is left after the purchase.
                if (|w_buy_rise) begin
                    if ($onehot(w_buy_rise) && (r_credit >= w_sel_price)) begin
                        w_nxt_vend  = w_buy_rise;
                        w_after_buy = r_credit - w_sel_price;
                    end else begin
                        w_nxt_deny = 1'b1;
                    end
                end
                w_nxt_credit = w_after_buy;
                if (|w_ins_rise) begin
                    case (w_ins_rise)
                        4'b0001: w_coin_val = 7'd1;
                        4'b0010: w_coin_val = 7'd5;
                        4'b0100: w_coin_val = 7'd10;
                        4'b1000: w_coin_val = 7'd50;
                        default: w_coin_val = 7'd0;   // multiple coins at once
                    endcase
                    w_sum = {1'b0, w_after_buy} + {1'b0, w_coin_val};
                    if ((w_coin_val != 7'd0) && (w_sum <= LP_MAX))
                        w_nxt_credit = w_sum[6:0];
                    else
                        w_nxt_coin_reject = 1'b1;
                end
                if (w_ret_rise && (w_nxt_credit != 7'd0))
                    w_nxt_state = S_CHANGE;
            end
            S_CHANGE: begin
                // Coins are refused while paying out; buy/ret are ignored.
                if (|w_ins_rise) w_nxt_coin_reject = 1'b1;
                if (r_credit >= 7'd50) begin
                    w_nxt_coin_out = 4'b1000; w_coin_val = 7'd50;
                end else if (r_credit >= 7'd10) begin
                    w_nxt_coin_out = 4'b0100; w_coin_val = 7'd10;
                end else if (r_credit >= 7'd5) begin
                    w_nxt_coin_out = 4'b0010; w_coin_val = 7'd5;
                end else begin
                    w_nxt_coin_out = 4'b0001; w_coin_val = 7'd1;
                end
                w_nxt_credit = r_credit - w_coin_val;
                if (w_nxt_credit == 7'd0) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_state = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    // State, credit and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_vend        <= '0;
            r_deny        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_coin_out    <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_credit      <= w_nxt_credit;
            r_vend        <= w_nxt_vend;
            r_deny        <= w_nxt_deny;
            r_coin_reject <= w_nxt_coin_reject;
            r_coin_out    <= w_nxt_coin_out;
            r_done        <= w_nxt_done;
        end
    end

    // Affordable LEDs, lit only while accepting purchases.
    always_comb begin
        w_led = '0;
        for (int i = 0; i < N_ITEMS; i++)
            w_led[i] = (r_state == S_IDLE) && (r_credit >= PRICES[7*i +: 7]);
    end

    function automatic logic [6:0] f_seg(input logic [6:0] d);
        case (d)
            7'd0:    f_seg = 7'b0111111;
            7'd1:    f_seg = 7'b0000110;
            7'd2:    f_seg = 7'b1011011;
            7'd3:    f_seg = 7'b1001111;
            7'd4:    f_seg = 7'b1100110;
            7'd5:    f_seg = 7'b1101101;
            7'd6:    f_seg = 7'b1111101;
            7'd7:    f_seg = 7'b0000111;
            7'd8:    f_seg = 7'b1111111;
            7'd9:    f_seg = 7'b1101111;
            default: f_seg = 7'b0000000;
        endcase
    endfunction

    assign w_tens = r_credit / 7'd10;
    assign w_ones = r_credit % 7'd10;

    assign LEDout      = w_led;
    assign vend        = r_vend;
    assign deny        = r_deny;
    assign coin_reject = r_coin_reject;
    assign coin_out    = r_coin_out;
    assign done        = r_done;
    assign Ten         = f_seg(w_tens);
    assign One         = f_seg(w_ones);

endmodule
